// File: rtl/lut_eval_pkg.sv
// lut_eval_pkg -- shared definitions for the lut_eval block.
//
// Contents:
//   N_IN_MIN / N_IN_MAX : legal range of the N_IN parameter of lut_eval.
//   n_in_legal()        : range check helper for N_IN.
//   sweep_state_e       : state encoding of the optional sweep FSM
//                         (present only when LUT_EVAL_SWEEP_EN is defined).
package lut_eval_pkg;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_DONE = 2'd2
  } sweep_state_e;

  function automatic bit n_in_legal(input int n);
    return (n >= N_IN_MIN) && (n <= N_IN_MAX);
  endfunction

endpackage

// File: rtl/lut_eval.sv
// lut_eval -- programmable N_IN-input Boolean function (truth-table LUT)
// with a one-deep valid/ready output stage and an optional table sweep.
//
// Configuration macro: LUT_EVAL_SWEEP_EN
//   defined   : sweep ports and sweep FSM are present.
//   undefined : sweep ports are absent and no sweep logic exists.
//
// Parameters:
//   N_IN  number of Boolean inputs (legal range in lut_eval_pkg, 2..8)
//   INIT  truth-table contents after reset (bit i = result for vector i)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_data table entry write (visible next cycle)
//   in_valid/in_ready/in_vec input vector handshake
//   out_valid/out_ready      result handshake
//   out_q, out_vec           result and the vector that produced it
//   sweep_start              start counting ones in the table (SWEEP_EN)
//   sweep_busy               sweep in RUN or DONE (SWEEP_EN)
//   sweep_done               one-cycle completion pulse (SWEEP_EN)
//   sweep_count              number of table entries equal to 1 (SWEEP_EN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data until the transfer; ready
// may depend on the consumer state but never on valid in the same cycle.
// in_ready = (!out_valid || out_ready) && !sweep_busy, so a held result
// blocks new vectors while a draining result allows one in the same cycle.
module lut_eval
  import lut_eval_pkg::*;
#(
  parameter int                  N_IN = 4,
  parameter logic [2**N_IN-1:0]  INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_q,
  output logic [N_IN-1:0] out_vec
`ifdef LUT_EVAL_SWEEP_EN
  ,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_count
`endif
);

  localparam int DEPTH = 2**N_IN;

  logic [DEPTH-1:0] lut_q, lut_d;
  logic             out_valid_q, out_valid_d;
  logic             out_q_q, out_q_d;
  logic [N_IN-1:0]  out_vec_q, out_vec_d;
  logic             busy_w;  // sweep owns the block (RUN or DONE)
  logic             run_w;   // sweep is reading the table
  logic             accept_w;

  // ---------------------------------------------------------------------
  // Optional sweep FSM: walks every table entry once and counts the ones.
  // ---------------------------------------------------------------------
`ifdef LUT_EVAL_SWEEP_EN
  // The index is one bit wider than the table address so the walk over
  // all 2**N_IN entries and the final count never wrap.
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(DEPTH - 1);

  sweep_state_e  state_q, state_d;
  logic [N_IN:0] idx_q, idx_d;
  logic [N_IN:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SW_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      SW_IDLE: begin
        if (sweep_start) begin
          state_d = SW_RUN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SW_RUN: begin
        cnt_d = cnt_q + (N_IN+1)'(lut_q[idx_q[N_IN-1:0]]);
        idx_d = idx_q + (N_IN+1)'(1);
        if (idx_q == LAST_IDX) begin
          state_d = SW_DONE;
        end
      end
      SW_DONE: begin
        state_d = SW_IDLE;
      end
      default: begin
        state_d = SW_IDLE;
      end
    endcase
  end

  assign busy_w      = (state_q != SW_IDLE);
  assign run_w       = (state_q == SW_RUN);
  assign sweep_busy  = busy_w;
  assign sweep_done  = (state_q == SW_DONE);
  assign sweep_count = cnt_q;
`else
  assign busy_w = 1'b0;
  assign run_w  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Truth table. A write lands at the clock edge, so an evaluation of the
  // same entry in the same cycle still sees the old value. Writes that
  // arrive while the sweep is reading the table are dropped so the count
  // reflects one consistent table.
  // ---------------------------------------------------------------------
  always_comb begin
    lut_d = lut_q;
    if (cfg_we && !run_w) begin
      lut_d[cfg_addr] = cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_q <= INIT;
    end else begin
      lut_q <= lut_d;
    end
  end

  // ---------------------------------------------------------------------
  // Evaluation and one-deep output register.
  // ---------------------------------------------------------------------
  assign in_ready = (!out_valid_q || out_ready) && !busy_w;
  assign accept_w = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_vec_d   = out_vec_q;
    if (accept_w) begin
      out_valid_d = 1'b1;
      out_q_d     = lut_q[in_vec];
      out_vec_d   = in_vec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q_q     <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_lut_eval.sv
// tb_lut_eval -- bench for lut_eval (N_IN=4, INIT=16'h8000, i.e. AND4).
// Sweep scenarios are built only when LUT_EVAL_SWEEP_EN is defined.
module tb_lut_eval;

  localparam int          N    = 4;
  localparam logic [15:0] INIT = 16'h8000;

  // ------------------------------------------------------------------
  // Clock / reset block
  // ------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [N-1:0] cfg_addr = '0;
  logic         cfg_data = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_q;
  logic [N-1:0] out_vec;
`ifdef LUT_EVAL_SWEEP_EN
  logic         sweep_start = 1'b0;
  logic         sweep_busy;
  logic         sweep_done;
  logic [N:0]   sweep_count;
`endif

  always #5 clk = ~clk;

  lut_eval #(.N_IN(N), .INIT(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_vec    (out_vec)
`ifdef LUT_EVAL_SWEEP_EN
    ,
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .sweep_count(sweep_count)
`endif
  );

  // ------------------------------------------------------------------
  // Reference model and scoreboard state
  // ------------------------------------------------------------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] model;              // what the truth table should hold
  logic [N:0]  exp_q[$];           // expected {out_q, out_vec}
  int          exp_cyc_q[$];       // cycle each expected result was accepted

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Monitor: checks each result against the queue, its 1-cycle latency
  // and that a held result does not change.
  // ------------------------------------------------------------------
  logic       held_v = 1'b0;
  logic [N:0] held   = '0;
  logic       prev_v = 1'b0;
  logic       prev_x = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
      prev_v = 1'b0;
      prev_x = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_q, out_vec}), 32'(held));
      end
      if (out_valid && (!prev_v || prev_x)) begin
        if (exp_cyc_q.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - exp_cyc_q[0]), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", 32'd1, 32'd0);
        end else begin
          chk("result", 32'({out_q, out_vec}), 32'(exp_q.pop_front()));
          void'(exp_cyc_q.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_q, out_vec};
      prev_v = out_valid;
      prev_x = out_valid && out_ready;
    end
  end

  // ------------------------------------------------------------------
  // Driver tasks (entered and left at posedge + 1)
  // ------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [N-1:0] vec, input logic ordy,
                       input logic we, input logic [N-1:0] addr, input logic d,
                       output logic acc);
    in_valid  = v;
    in_vec    = vec;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_data  = d;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      // Evaluation sees the table as it was before this cycle's write.
      exp_q.push_back({model[vec], vec});
      exp_cyc_q.push_back(cyc);
    end
    if (we) model[addr] = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] vec, input logic ordy);
    logic acc;
    cycle(1'b1, vec, ordy, 1'b0, '0, 1'b0, acc);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, 1'b0, '0, 1'b0, acc);
  endtask

  task automatic write_entry(input logic [N-1:0] addr, input logic d);
    logic acc;
    cycle(1'b0, '0, 1'b1, 1'b1, addr, d, acc);
  endtask

  task automatic load_table(input logic [15:0] t);
    logic [15:0] tv;
    tv = t;
    for (int i = 0; i < 16; i++) write_entry(N'(i), tv[i]);
  endtask

  task automatic do_reset_clear();
    exp_q.delete();
    exp_cyc_q.delete();
    model = INIT;
  endtask

`ifdef LUT_EVAL_SWEEP_EN
  task automatic run_sweep(input logic second, input logic drop);
    int         busy_n;
    int         done_n;
    logic [N:0] expc;
    busy_n = 0;
    done_n = 0;
    expc   = (N+1)'($countones(model));
    sweep_start = 1'b1;
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sweep_busy) begin
        busy_n++;
        chk("sweep_in_ready", 32'(in_ready), 32'd0);
      end
      if (sweep_done) begin
        done_n++;
        chk("sweep_count", 32'(sweep_count), 32'(expc));
      end
      if (k > 0 && !sweep_busy) break;
      @(posedge clk);
      #1;
      sweep_start = second && (k == 3);
      cfg_we      = drop && (k == 5);
      cfg_addr    = 4'h3;
      cfg_data    = 1'b0;
    end
    sweep_start = 1'b0;
    cfg_we      = 1'b0;
    chk("sweep_busy_cycles", 32'(busy_n), 32'd17);
    chk("sweep_done_pulses", 32'(done_n), 32'd1);
    chk("sweep_count_held", 32'(sweep_count), 32'(expc));
    @(posedge clk);
    #1;
  endtask
`endif

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    logic acc;
    model = INIT;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
`ifdef LUT_EVAL_SWEEP_EN
    chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_sweep_count", 32'(sweep_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // AND4 from reset contents
    send(4'hF, 1'b1);
    send(4'hE, 1'b1);
    idle(2, 1'b1);

    // XOR4 table, all vectors back-to-back
    load_table(16'h6996);
    for (int i = 0; i < 16; i++) send(N'(i), 1'b1);
    idle(2, 1'b1);
`ifdef LUT_EVAL_SWEEP_EN
    run_sweep(1'b0, 1'b0);
`endif

    // Backpressure: result 1 pending for 3 cycles
    send(4'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h2, 1'b0, 1'b0, '0, 1'b0, acc);
      chk("stall_in_ready", 32'(acc), 32'd0);
    end
    send(4'h2, 1'b1);
    idle(2, 1'b1);

    // Same-cycle write and evaluate of entry F
    write_entry(4'hF, 1'b1);
    cycle(1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 1'b0, acc);
    chk("wr_eval_accept", 32'(acc), 32'd1);
    send(4'hF, 1'b1);
    idle(2, 1'b1);

    // Random traffic with writes and backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), N'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
            N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc);
    end
    idle(3, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset with a pending result of 1
    write_entry(4'h5, 1'b1);
    send(4'h5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_q", 32'(out_q), 32'd0);
    chk("arst_out_vec", 32'(out_vec), 32'd0);
    do_reset_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'hF, 1'b1);
    send(4'h5, 1'b1);
    send(4'hE, 1'b1);
    idle(2, 1'b1);

`ifdef LUT_EVAL_SWEEP_EN
    // All-ones table; second start and a cfg write during RUN are ignored
    load_table(16'hFFFF);
    run_sweep(1'b1, 1'b1);
    send(4'h3, 1'b1);
    idle(2, 1'b1);

    // Reset during RUN cycle 5
    begin
      int dn;
      sweep_start = 1'b1;
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_sweep_busy", 32'(sweep_busy), 32'd0);
      chk("arst_sweep_done", 32'(sweep_done), 32'd0);
      chk("arst_sweep_count", 32'(sweep_count), 32'd0);
      do_reset_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      dn = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (sweep_done || sweep_busy) dn++;
      end
      chk("no_sweep_after_reset", 32'(dn), 32'd0);
      @(posedge clk);
      #1;
      send(4'hF, 1'b1);
      send(4'hE, 1'b1);
      idle(2, 1'b1);
    end
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
